// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Brief    : Two-port round-robin arbiter/sequencer for a single-port RAM.
//             One access per three cycles: IDLE -> ACCESS -> RESP.
//  Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          Mem_Read,
    output logic          Mem_Write,
    output logic [AW-1:0] Mem_Addr,
    output logic [DW-1:0] M_W_Data,
    input  logic [DW-1:0] M_R_Data,
    output logic          busy,
    output logic          grant_id
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic          gid_q,    gid_d;
    logic          we_q,     we_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          win;

    always_comb begin
        state_d  = state_q;
        gid_d    = gid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the requester not served last wins.
                    win     = (m0_req && m1_req) ? ~gid_q : m1_req;
                    gid_d   = win;
                    we_d    = win ? m1_we    : m0_we;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (gid_q) rdata1_d = M_R_Data;
                    else       rdata0_d = M_R_Data;
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gid_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode from registered state, so reset drops them at once.
    assign Mem_Read  = (state_q == S_ACCESS) && !we_q;
    assign Mem_Write = (state_q == S_ACCESS) &&  we_q;
    assign Mem_Addr  = addr_q;
    assign M_W_Data  = wdata_q;
    assign m0_ack    = (state_q == S_RESP) && !gid_q;
    assign m1_ack    = (state_q == S_RESP) &&  gid_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Brief    : Self-checking bench for ram_arbiter with a transaction-level
//             reference model and a behavioural 64x32 RAM.
//  Revision : 1.0
// ============================================================================
module tb_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          Mem_Read, Mem_Write;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] M_W_Data, M_R_Data;
    logic          busy, grant_id;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
        .M_W_Data(M_W_Data), .M_R_Data(M_R_Data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural RAM in front of which the arbiter sits.
    logic [DW-1:0] ram [0:63];
    logic          ram_clr;
    always @(posedge clk) begin
        if (ram_clr) for (int i = 0; i < 64; i++) ram[i] <= '0;
        else if (Mem_Write) ram[Mem_Addr] <= M_W_Data;
    end
    assign M_R_Data = ram[Mem_Addr];

    // Reference model: a transaction is granted, performed one cycle later,
    // acknowledged the cycle after that; ph counts cycles since grant.
    int          ph = 0;
    bit          m_last = 1'b1;
    bit          m_win;
    bit          t_we = 1'b0;
    logic [5:0]  t_addr = '0;
    logic [31:0] t_wd = '0;
    logic [31:0] e_rd [2];
    logic [31:0] ref_mem [64];

    always @(posedge clk or posedge rst) begin
        if (ram_clr) for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        if (rst) begin
            ph = 0; m_last = 1'b1; t_we = 1'b0; t_addr = '0; t_wd = '0;
            e_rd[0] = '0; e_rd[1] = '0;
        end else if (ph == 0) begin
            if (m0_req || m1_req) begin
                if (m0_req && m1_req) m_win = !m_last;
                else                  m_win = m1_req;
                m_last = m_win;
                t_we   = m_win ? m1_we    : m0_we;
                t_addr = m_win ? m1_addr  : m0_addr;
                t_wd   = m_win ? m1_wdata : m0_wdata;
                ph = 1;
            end
        end else if (ph == 1) begin
            if (t_we) ref_mem[t_addr] = t_wd;
            else      e_rd[m_last]    = ref_mem[t_addr];
            ph = 2;
        end else begin
            ph = 0;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      32'(busy),      32'(ph != 0));
            chk("Mem_Read",  32'(Mem_Read),  32'(ph == 1 && !t_we));
            chk("Mem_Write", 32'(Mem_Write), 32'(ph == 1 && t_we));
            chk("Mem_Addr",  32'(Mem_Addr),  32'(t_addr));
            chk("M_W_Data",  M_W_Data,       t_wd);
            chk("m0_ack",    32'(m0_ack),    32'(ph == 2 && !m_last));
            chk("m1_ack",    32'(m1_ack),    32'(ph == 2 && m_last));
            chk("grant_id",  32'(grant_id),  32'(m_last));
            chk("m0_rdata",  m0_rdata,       e_rd[0]);
            chk("m1_rdata",  m1_rdata,       e_rd[1]);
            chk("strobe_excl", 32'(Mem_Read & Mem_Write), 32'd0);
        end
    end

    // Issue one request from an idle arbiter and wait for its ack.
    task automatic do_req(input bit p, input bit we, input logic [5:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        int lat = 0;
        int strb = 0;
        bit got = 1'b0;
        if (p) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = wd; end
        else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = wd; end
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (Mem_Read || Mem_Write) strb++;
            got = p ? m1_ack : m0_ack;
        end
        m0_req = 0; m1_req = 0;
        rd = p ? m1_rdata : m0_rdata;
        chk("req_latency", 32'(lat), 32'd2);
        chk("strobe_cycles", 32'(strb), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst = 1;
        @(negedge clk); @(negedge clk); #2 rst = 0;
    endtask

    logic [31:0] rd;
    int          acks;
    int          t_prev, t_now;
    int          order [4];
    int          cyc;
    bit          pend0, pend1;

    initial begin
        rst = 1; ram_clr = 1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        ram_clr = 0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd1);
        chk("rst_mem_addr", 32'(Mem_Addr), 32'd0);
        #2 rst = 0;
        chk_en = 1;

        // m0 write then read of address 0
        @(negedge clk);
        do_req(0, 1, 6'd0, 32'hFFFF_FFFF, rd);
        chk("wr_no_rdata", rd, 32'h0);
        @(negedge clk);
        do_req(0, 0, 6'd0, 32'h0, rd);
        chk("rd_addr0", rd, 32'hFFFF_FFFF);
        chk("m1_rdata_untouched", m1_rdata, 32'h0);

        // preload via m1, then reset so m0 wins the first tie
        @(negedge clk); do_req(1, 1, 6'd5,  32'h1234_5678, rd);
        @(negedge clk); do_req(1, 1, 6'd63, 32'hDEAD_BEEF, rd);
        pulse_reset();

        // both requesters held: reads of 5 and 63 alternate
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 6'd5;
        m1_req = 1; m1_we = 0; m1_addr = 6'd63;
        acks = 0; cyc = 0; t_prev = 0;
        while (acks < 4 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (m0_ack || m1_ack) begin
                order[acks] = m1_ack ? 1 : 0;
                if (acks > 0) chk("rr_ack_spacing", 32'(cyc - t_prev), 32'd3);
                t_prev = cyc;
                if (m0_ack) chk("rr_m0_rdata", m0_rdata, 32'h1234_5678);
                if (m1_ack) chk("rr_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
                acks++;
            end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_ack_count", 32'(acks), 32'd4);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

        // m1 alone: four back-to-back writes with req held
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 6'd62; m1_wdata = 32'hA000_0000;
        acks = 0; cyc = 0; t_prev = 0;
        while (acks < 4 && cyc < 20) begin
            @(negedge clk); cyc++;
            chk("m1_only_grant", 32'(grant_id), 32'd1);
            if (m1_ack) begin
                if (acks > 0) chk("wr_ack_spacing", 32'(cyc - t_prev), 32'd3);
                t_prev = cyc;
                acks++;
                m1_addr  = m1_addr + 6'd1;
                m1_wdata = 32'hA000_0000 + 32'(acks);
            end
        end
        m1_req = 0;
        chk("wr_ack_count", 32'(acks), 32'd4);

        // reset in the middle of an m1 read
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = 6'd5;
        @(negedge clk);
        chk("pre_rst_mem_read", 32'(Mem_Read), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst_mem_read_drop", 32'(Mem_Read), 32'd0);
        chk("rst_busy_drop", 32'(busy), 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        m1_req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", 32'(m1_ack), 32'd0);
        end
        #2 rst = 0;
        @(negedge clk);
        do_req(1, 0, 6'd5, 32'h0, rd);
        chk("post_rst_read", rd, 32'h1234_5678);

        // m0 drops req right after grant
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 6'd1;
        @(negedge clk);
        m0_req = 0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ack) begin
                acks++;
                chk("drop_rdata", m0_rdata, 32'hA000_0003);
            end
        end
        chk("drop_ack_count", 32'(acks), 32'd1);
        chk("drop_idle_busy", 32'(busy), 32'd0);

        // randomized traffic, each requester holding its request until ack
        pend0 = 0; pend1 = 0;
        repeat (600) begin
            @(negedge clk);
            if (pend0 && m0_ack) begin pend0 = 0; m0_req = 0; end
            if (pend1 && m1_ack) begin pend1 = 0; m1_req = 0; end
            if (!pend0 && ($urandom % 3 == 0)) begin
                pend0 = 1; m0_req = 1; m0_we = 1'($urandom);
                m0_addr = 6'($urandom); m0_wdata = $urandom;
            end
            if (!pend1 && ($urandom % 3 == 0)) begin
                pend1 = 1; m1_req = 1; m1_we = 1'($urandom);
                m1_addr = 6'($urandom); m1_wdata = $urandom;
            end
        end
        m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 64x32 single-port data RAM.
- Lets two requesters share the RAM's Mem_Read / Mem_Write / Mem_Addr / M_W_Data / M_R_Data port, for example the fetch path and the load/store path of the multi-cycle CPU.
- Serialises accesses and guarantees that read and write strobes are never both active.
- Returns read data and a one-cycle acknowledge to the requester that was granted.

Parameters:
- AW, 6, RAM address width (64 words)
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  requester 0 access request; held until m0_ack
- m0_we  in  1  requester 0: 1 = write, 0 = read
- m0_addr  in  AW  requester 0 word address
- m0_wdata  in  DW  requester 0 write data
- m0_ack  out  1  requester 0 completion pulse (one cycle)
- m0_rdata  out  DW  requester 0 read data register
- m1_req / m1_we / m1_addr / m1_wdata  in  1/1/AW/DW  requester 1, same meaning as requester 0
- m1_ack / m1_rdata  out  1/DW  requester 1, same meaning as requester 0
- Mem_Read  out  1  RAM read strobe
- Mem_Write  out  1  RAM write strobe
- Mem_Addr  out  AW  RAM address
- M_W_Data  out  DW  RAM write data
- M_R_Data  in  DW  RAM read data (combinational from Mem_Addr)
- busy  out  1  high in ACCESS and RESP
- grant_id  out  1  requester currently or last served

Behaviour:
- Reset (async, immediate): state=IDLE; Mem_Read, Mem_Write, Mem_Addr, M_W_Data, m0_ack, m1_ack, m0_rdata, m1_rdata, busy all 0; grant_id=1, so requester 0 wins the first tie.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Mem_Read=Mem_Write=0.
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester != grant_id (strict round-robin).
  - On grant: latch we/addr/wdata of the winner into internal registers, set grant_id, go to ACCESS.
- ACCESS (exactly one cycle):
  - Drive Mem_Addr and M_W_Data from the latched registers.
  - Mem_Write = latched we; Mem_Read = ~latched we.
  - On a read, capture M_R_Data at the closing edge into rdata of the granted requester; the other requester's rdata is unchanged.
  - Go to RESP.
- RESP (one cycle):
  - Mem_Read=Mem_Write=0; Mem_Addr and M_W_Data hold their values.
  - Granted requester's ack=1; the other ack=0.
  - Go to IDLE.
- Latency and throughput:
  - req sampled high in IDLE at edge N -> ACCESS during cycle N..N+1 -> ack high during cycle N+1..N+2.
  - One access per 3 cycles.
  - Read data is valid in mX_rdata in the same cycle as mX_ack and held until the next read by that requester.
- Handshake:
  - A requester keeps req, we, addr and wdata stable until it sees ack.
  - Inputs are latched at grant, so changes after grant are ignored.
  - req dropped after grant: the transaction still completes and ack still pulses.
  - req still high in the IDLE cycle after RESP: treated as a new request.
- Invariants:
  - Mem_Read & Mem_Write == 0 always.
  - m0_ack & m1_ack == 0 always.
  - busy = (state != IDLE).
- Writes never modify m0_rdata or m1_rdata.
- Addresses wrap naturally within AW bits; no out-of-range handling.
- Reset asserted during ACCESS or RESP:
  - Transaction aborted; no ack issued.
  - Strobes drop asynchronously.
  - A write already presented during ACCESS may have occurred; this is acceptable.

Test Plan:
- m0 write 0x0000_0000 -> 0xFFFF_FFFF:
  - Mem_Write=1 and Mem_Addr=0 for exactly one cycle.
  - m0_ack one cycle later.
  - m0_rdata stays 0.
- m0 read addr 0 after that write -> Mem_Read=1 for one cycle; m0_rdata=0xFFFF_FFFF with m0_ack; m1_rdata still 0.
- m0 and m1 both held high with reads of addr 5 (holds 0x1234_5678) and addr 63 (holds 0xDEAD_BEEF) -> grants alternate 0,1,0,1 (m0 first after reset); acks 3 cycles apart; rdatas match.
- m1 alone issues 4 back-to-back writes to addr 62, 63, 0, 1 (req held continuously) -> four m1_ack pulses, 3 cycles apart; strobes never overlap; grant_id stays 1.
- rst pulsed mid-ACCESS of an m1 read -> Mem_Read falls immediately; no m1_ack; all outputs 0 while rst is high; next request after release is served normally.
- m0 drops req one cycle after grant -> ACCESS and RESP still execute and m0_ack pulses once; IDLE afterwards with busy=0.
